// File: rtl/odd_pipe_pkg.sv
// rtl/odd_pipe_pkg.sv - shared opcodes, packet layout and unit constants for the odd pipe
// Purpose: opcode enum for every odd-pipe op (plus NOP), result packet field offsets,
//          unit-id and latency constants, and a packet builder.
// Packet (143 bits, ISA bit 0 = MSB = Verilog bit 142):
//   [142:15] value, [14:8] rt address, [7] reg-write enable, [6:4] unit id, [3:0] latency
package odd_pipe_pkg;

    localparam int LS_AW  = 15;
    localparam int STAGES = 7;
    localparam int PKT_W  = 143;

    localparam int PKT_VAL_LSB  = 15;
    localparam int PKT_RT_LSB   = 8;
    localparam int PKT_WE_BIT   = 7;
    localparam int PKT_UNIT_LSB = 4;
    localparam int PKT_LAT_LSB  = 0;

    localparam logic [2:0] UNIT_NONE = 3'd0;
    localparam logic [2:0] UNIT_PERM = 3'd1;
    localparam logic [2:0] UNIT_LS   = 3'd2;
    localparam logic [2:0] UNIT_BR   = 3'd3;

    localparam logic [3:0] LAT_NONE = 4'd0;
    localparam logic [3:0] LAT_PERM = 4'd4;
    localparam logic [3:0] LAT_LOAD = 4'd6;

    typedef enum logic [4:0] {
        NOP      = 5'd0,
        SHLQBI   = 5'd1,
        SHLQBII  = 5'd2,
        ROTQBI   = 5'd3,
        ROTQBII  = 5'd4,
        SHLQBY   = 5'd5,
        SHLQBYI  = 5'd6,
        SHLQBYBI = 5'd7,
        ROTQBY   = 5'd8,
        ROTQBYI  = 5'd9,
        ROTQBYBI = 5'd10,
        GBB      = 5'd11,
        GBH      = 5'd12,
        GB       = 5'd13,
        LQD      = 5'd14,
        LQA      = 5'd15,
        LQX      = 5'd16,
        STQD     = 5'd17,
        STQA     = 5'd18,
        STQX     = 5'd19,
        BR       = 5'd20,
        BRA      = 5'd21,
        BI       = 5'd22,
        BRZ      = 5'd23,
        BRNZ     = 5'd24
    } opcode_t;

    function automatic logic [PKT_W-1:0] make_packet(input logic [127:0] value,
                                                      input logic [6:0]   rt,
                                                      input logic         we,
                                                      input logic [2:0]   unit,
                                                      input logic [3:0]   lat);
        return {value, rt, we, unit, lat};
    endfunction

endpackage

// File: rtl/odd_permute.sv
// rtl/odd_permute.sv - combinational quadword shift/rotate/gather-bits unit
// Ports:
//   op      in  opcode_t  current opcode (non-permute ops yield zero)
//   ra      in  128       quadword operand, ISA bit 0 = Verilog bit 127
//   rb_slot in  32        preferred slot of rb (ISA rb[0:31])
//   i7      in  7         I7 immediate
//   value   out 128       permute result
module odd_permute
    import odd_pipe_pkg::*;
(
    input  opcode_t      op,
    input  logic [127:0] ra,
    input  logic [31:0]  rb_slot,
    input  logic [6:0]   i7,
    output logic [127:0] value
);

    logic [6:0]   amt;
    logic         rot;
    logic         zero;
    logic         is_shift;
    logic [4:0]   byte_cnt;
    logic [255:0] dbl;
    logic [127:0] gather;
    logic         unused_bits;

    // ISA field rb[a:b] of the preferred slot maps to rb_slot[31-a:31-b].
    always_comb begin
        amt      = '0;
        rot      = 1'b0;
        is_shift = 1'b1;
        byte_cnt = '0;
        case (op)
            SHLQBI:   amt = {4'b0, rb_slot[2:0]};
            SHLQBII:  amt = {4'b0, i7[2:0]};
            ROTQBI:   begin rot = 1'b1; amt = {4'b0, rb_slot[2:0]}; end
            ROTQBII:  begin rot = 1'b1; amt = {4'b0, i7[2:0]}; end
            SHLQBY:   byte_cnt = rb_slot[4:0];
            SHLQBYI:  byte_cnt = i7[4:0];
            SHLQBYBI: byte_cnt = rb_slot[7:3];
            ROTQBY:   begin rot = 1'b1; byte_cnt = {1'b0, rb_slot[3:0]}; end
            ROTQBYI:  begin rot = 1'b1; byte_cnt = {1'b0, i7[3:0]}; end
            ROTQBYBI: begin rot = 1'b1; byte_cnt = {1'b0, rb_slot[6:3]}; end
            default:  is_shift = 1'b0;
        endcase
        if (byte_cnt != 5'd0) begin
            amt = {byte_cnt[3:0], 3'b000};
        end
        // Only shifts can carry bit 4; 16 or more bytes shifts everything out.
        zero = byte_cnt[4];
    end

    // Upper half of the doubled word is the shift (zero fill) or rotate (wrap).
    assign dbl = {ra, (rot ? ra : 128'b0)} << amt;

    always_comb begin
        gather = '0;
        case (op)
            GBB: for (int i = 0; i < 16; i++) gather[111-i] = ra[120-8*i];
            GBH: for (int i = 0; i < 8; i++)  gather[103-i] = ra[112-16*i];
            GB:  for (int i = 0; i < 4; i++)  gather[99-i]  = ra[96-32*i];
            default: gather = '0;
        endcase
    end

    always_comb begin
        value = '0;
        if (is_shift) begin
            value = zero ? 128'b0 : dbl[255:128];
        end else begin
            value = gather;
        end
    end

    assign unused_bits = ^{rb_slot[31:8], i7[6:5], dbl[127:0]};

endmodule

// File: rtl/odd_pipe.sv
// rtl/odd_pipe.sv - SPU-lite odd execution pipe: permute, local-store load/store, branch
// Build option: ODD_PIPE_BRANCH_EN enables the branch unit; otherwise branches act as NOP.
// Ports:
//   clock, reset (async, active-high)
//   op_input_op_code, ra_input, rb_input, rt_address_input, I7/I10/I16/I18_input (I18 ignored)
//   LS_address/LS_data_output/LS_wrt_en  combinational local-store request
//   LS_data_input                        local-store read data for LS_address
//   fw_op_st_1..7, out_op                registered result packets (out_op = stage 7)
//   PC_input, PC_output, branch_taken    branch resolution, registered
module odd_pipe
    import odd_pipe_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  opcode_t      op_input_op_code,
    input  logic [127:0] ra_input,
    input  logic [127:0] rb_input,
    input  logic [6:0]   rt_address_input,
    input  logic [6:0]   I7_input,
    input  logic [9:0]   I10_input,
    input  logic [15:0]  I16_input,
    input  logic [17:0]  I18_input,
    output logic [14:0]  LS_address,
    input  logic [127:0] LS_data_input,
    output logic [127:0] LS_data_output,
    output logic         LS_wrt_en,
    output logic [142:0] fw_op_st_1,
    output logic [142:0] fw_op_st_2,
    output logic [142:0] fw_op_st_3,
    output logic [142:0] fw_op_st_4,
    output logic [142:0] fw_op_st_5,
    output logic [142:0] fw_op_st_6,
    output logic [142:0] fw_op_st_7,
    output logic [142:0] out_op,
    output logic         branch_taken,
    input  logic [31:0]  PC_input,
    output logic [31:0]  PC_output
);

    logic [31:0]      ra_slot;
    logic [31:0]      rb_slot;
    logic [31:0]      i16_word;
    logic [31:0]      ea;
    logic             is_store;
    logic [127:0]     perm_value;
    logic [PKT_W-1:0] new_pkt;
    logic [PKT_W-1:0] st [1:STAGES];
    logic             taken_nxt;
    logic [31:0]      pc_nxt;
    logic             unused_top;

    assign ra_slot  = ra_input[127:96];
    assign rb_slot  = rb_input[127:96];
    assign i16_word = {{14{I16_input[15]}}, I16_input, 2'b00};

    odd_permute u_permute (
        .op      (op_input_op_code),
        .ra      (ra_input),
        .rb_slot (rb_slot),
        .i7      (I7_input),
        .value   (perm_value)
    );

    always_comb begin
        ea       = '0;
        is_store = 1'b0;
        case (op_input_op_code)
            LQD:  ea = ra_slot + {{18{I10_input[9]}}, I10_input, 4'b0000};
            LQA:  ea = i16_word;
            LQX:  ea = ra_slot + rb_slot;
            STQD: begin ea = ra_slot + {{18{I10_input[9]}}, I10_input, 4'b0000}; is_store = 1'b1; end
            STQA: begin ea = i16_word; is_store = 1'b1; end
            STQX: begin ea = ra_slot + rb_slot; is_store = 1'b1; end
            default: ea = '0;
        endcase
    end

    // Quadword aligned: keep 15 address bits, drop the byte-within-quadword nibble.
    assign LS_address     = {ea[LS_AW-1:4], 4'b0000};
    assign LS_data_output = rb_input;
    assign LS_wrt_en      = is_store & ~reset;

    always_comb begin
        new_pkt = '0;
        case (op_input_op_code)
            SHLQBI, SHLQBII, ROTQBI, ROTQBII, SHLQBY, SHLQBYI, SHLQBYBI,
            ROTQBY, ROTQBYI, ROTQBYBI, GBB, GBH, GB:
                new_pkt = make_packet(perm_value, rt_address_input, 1'b1, UNIT_PERM, LAT_PERM);
            LQD, LQA, LQX:
                new_pkt = make_packet(LS_data_input, rt_address_input, 1'b1, UNIT_LS, LAT_LOAD);
            STQD, STQA, STQX:
                new_pkt = make_packet(128'b0, 7'd0, 1'b0, UNIT_LS, LAT_NONE);
`ifdef ODD_PIPE_BRANCH_EN
            BR, BRA, BI, BRZ, BRNZ:
                new_pkt = make_packet(128'b0, 7'd0, 1'b0, UNIT_BR, LAT_NONE);
`endif
            default: new_pkt = '0;
        endcase
    end

`ifdef ODD_PIPE_BRANCH_EN
    always_comb begin
        taken_nxt = 1'b0;
        pc_nxt    = PC_input + 32'd4;
        case (op_input_op_code)
            BR:   begin taken_nxt = 1'b1; pc_nxt = PC_input + i16_word; end
            BRA:  begin taken_nxt = 1'b1; pc_nxt = i16_word; end
            BI:   begin taken_nxt = 1'b1; pc_nxt = ra_slot & ~32'd3; end
            BRZ:  if (rb_slot == 32'd0) begin taken_nxt = 1'b1; pc_nxt = PC_input + i16_word; end
            BRNZ: if (rb_slot != 32'd0) begin taken_nxt = 1'b1; pc_nxt = PC_input + i16_word; end
            default: taken_nxt = 1'b0;
        endcase
    end
`else
    assign taken_nxt = 1'b0;
    assign pc_nxt    = PC_input + 32'd4;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= STAGES; i++) st[i] <= '0;
            branch_taken <= 1'b0;
            PC_output    <= '0;
        end else begin
            st[1] <= new_pkt;
            for (int i = 2; i <= STAGES; i++) st[i] <= st[i-1];
            branch_taken <= taken_nxt;
            PC_output    <= pc_nxt;
        end
    end

    assign fw_op_st_1 = st[1];
    assign fw_op_st_2 = st[2];
    assign fw_op_st_3 = st[3];
    assign fw_op_st_4 = st[4];
    assign fw_op_st_5 = st[5];
    assign fw_op_st_6 = st[6];
    assign fw_op_st_7 = st[7];
    assign out_op     = st[7];

    assign unused_top = ^{I18_input, ea[31:LS_AW], ea[3:0]};

endmodule

// File: tb/tb_odd_pipe.sv
// tb/tb_odd_pipe.sv - directed self-checking bench for odd_pipe
module tb_odd_pipe;
    import odd_pipe_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    opcode_t      op = NOP;
    logic [127:0] ra = '0, rb = '0, ls_rd = '0;
    logic [6:0]   rt = '0, i7 = '0;
    logic [9:0]   i10 = '0;
    logic [15:0]  i16 = '0;
    logic [17:0]  i18 = '0;
    logic [31:0]  pc_in = '0;
    logic [14:0]  ls_addr;
    logic [127:0] ls_wd;
    logic         ls_we;
    logic [142:0] s1, s2, s3, s4, s5, s6, s7, oo;
    logic         taken;
    logic [31:0]  pc_out;
    logic [142:0] stages_or;
    int           checks = 0;
    int           errors = 0;

    assign stages_or = s1 | s2 | s3 | s4 | s5 | s6 | s7 | oo;

    always #5 clock = ~clock;

    odd_pipe dut (
        .clock(clock), .reset(reset), .op_input_op_code(op),
        .ra_input(ra), .rb_input(rb), .rt_address_input(rt),
        .I7_input(i7), .I10_input(i10), .I16_input(i16), .I18_input(i18),
        .LS_address(ls_addr), .LS_data_input(ls_rd), .LS_data_output(ls_wd), .LS_wrt_en(ls_we),
        .fw_op_st_1(s1), .fw_op_st_2(s2), .fw_op_st_3(s3), .fw_op_st_4(s4),
        .fw_op_st_5(s5), .fw_op_st_6(s6), .fw_op_st_7(s7), .out_op(oo),
        .branch_taken(taken), .PC_input(pc_in), .PC_output(pc_out)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue1(input opcode_t o, input logic [127:0] a, input logic [127:0] b,
                          input logic [6:0] imm7, input logic [127:0] exp, input string name);
        op = o; ra = a; rb = b; i7 = imm7; rt = 7'd3;
        tick();
        checks++;
        if (s1[142:15] !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, s1[142:15], exp);
        end
        op = NOP;
    endtask

    task automatic test_reset();
        op = STQD; ra = {32'h100, 96'h0};
        #12;
        checks++;
        if (stages_or !== '0) begin errors++; $display("FAIL reset_stages: got %h expected 0", stages_or); end
        checks++;
        if (ls_we !== 1'b0) begin errors++; $display("FAIL reset_ls_we: got %b expected 0", ls_we); end
        checks++;
        if ({taken, pc_out} !== 33'd0) begin errors++; $display("FAIL reset_branch: got %b/%h expected 0/0", taken, pc_out); end
        @(negedge clock);
        reset = 1'b0; op = NOP; ra = '0;
        #1;
    endtask

    task automatic test_shift_bits();
        op = SHLQBI; ra = 128'h1; rb = {32'h3, 96'h0}; rt = 7'd9;
        tick();
        op = NOP;
        tick(); tick(); tick();
        checks++;
        if (s4[142:15] !== 128'h8) begin errors++; $display("FAIL shlqbi_st4_value: got %h expected 8", s4[142:15]); end
        checks++;
        if (s4[14:0] !== {7'd9, 1'b1, 3'd1, 4'd4}) begin
            errors++; $display("FAIL shlqbi_st4_fields: got %h expected %h", s4[14:0], {7'd9, 1'b1, 3'd1, 4'd4});
        end
        issue1(SHLQBII, 128'h1, '0, 7'd5, 128'h20, "shlqbii");
        issue1(ROTQBI, {1'b1, 127'b0}, {32'h1, 96'h0}, '0, 128'h1, "rotqbi_wrap");
        issue1(SHLQBI, 128'hDEAD, {32'hFFFFFFF8, 96'h0}, '0, 128'hDEAD, "shlqbi_count0");
        issue1(ROTQBII, {4'hC, 124'h0}, '0, 7'd4, 128'hC, "rotqbii");
    endtask

    task automatic test_rotate();
        issue1(ROTQBYI, {8'hAA, 120'h0}, '0, 7'd1, 128'hAA, "rotqbyi");
        issue1(ROTQBY, 128'h0123456789ABCDEF_FEDCBA9876543210, '0, '0,
               128'h0123456789ABCDEF_FEDCBA9876543210, "rotqby_zero");
        issue1(ROTQBYBI, {16'hBEEF, 112'h0}, {32'h10, 96'h0}, '0, 128'hBEEF, "rotqbybi");
    endtask

    task automatic test_shift_bytes();
        issue1(SHLQBY, '1, {32'd16, 96'h0}, '0, 128'h0, "shlqby_16");
        issue1(SHLQBY, 128'hFF, {32'd15, 96'h0}, '0, {8'hFF, 120'h0}, "shlqby_15");
        issue1(SHLQBYI, '1, '0, 7'd16, 128'h0, "shlqbyi_16");
        issue1(SHLQBYI, 128'hFF, '0, 7'd1, 128'hFF00, "shlqbyi_1");
        issue1(SHLQBYBI, 128'h1, {32'h18, 96'h0}, '0, 128'h1000000, "shlqbybi");
    endtask

    task automatic test_gather();
        issue1(GBB, {8{16'h01FE}}, '0, '0, {32'h0000AAAA, 96'h0}, "gbb");
        issue1(GBH, {16'h0001, 16'hFFF1, 16'h0000, 16'hFFFE, 16'h0, 16'h0, 16'h0, 16'h8001},
               '0, '0, {32'h000000C1, 96'h0}, "gbh");
        issue1(GB, {32'h1, 32'hFFFFFFFE, 32'h3, 32'h1}, '0, '0, {32'h0000000B, 96'h0}, "gb");
    endtask

    task automatic test_load_store();
        op = STQD; ra = {32'h100, 96'h0}; rb = 128'hCAFE; i10 = 10'd2;
        #1;
        checks++;
        if (ls_addr !== 15'h120) begin errors++; $display("FAIL stqd_addr: got %h expected 120", ls_addr); end
        checks++;
        if (ls_we !== 1'b1) begin errors++; $display("FAIL stqd_we: got %b expected 1", ls_we); end
        checks++;
        if (ls_wd !== 128'hCAFE) begin errors++; $display("FAIL stqd_data: got %h expected cafe", ls_wd); end
        tick();
        op = NOP;
        #1;
        checks++;
        if (ls_we !== 1'b0) begin errors++; $display("FAIL stqd_we_drop: got %b expected 0", ls_we); end
        checks++;
        if (s1 !== {128'h0, 7'd0, 1'b0, 3'd2, 4'd0}) begin errors++; $display("FAIL stqd_packet: got %h", s1); end

        op = LQD; rt = 7'd77; ls_rd = 128'h1122334455667788_99AABBCCDDEEFF00;
        #1;
        checks++;
        if (ls_addr !== 15'h120) begin errors++; $display("FAIL lqd_addr: got %h expected 120", ls_addr); end
        tick();
        checks++;
        if (s1 !== {128'h1122334455667788_99AABBCCDDEEFF00, 7'd77, 1'b1, 3'd2, 4'd6}) begin
            errors++; $display("FAIL lqd_packet: got %h", s1);
        end
        op = LQA; i16 = 16'hFFFF;
        #1;
        checks++;
        if (ls_addr !== 15'h7FF0) begin errors++; $display("FAIL lqa_addr: got %h expected 7ff0", ls_addr); end
        op = LQX; ra = {32'h7FF8, 96'h0}; rb = {32'h10, 96'h0};
        #1;
        checks++;
        if (ls_addr !== 15'h0000) begin errors++; $display("FAIL lqx_wrap: got %h expected 0", ls_addr); end
        op = LQD; ra = {32'h100, 96'h0}; i10 = 10'h3FF;
        #1;
        checks++;
        if (ls_addr !== 15'h00F0) begin errors++; $display("FAIL lqd_neg: got %h expected f0", ls_addr); end
        op = NOP;
        tick();
    endtask

    task automatic branch_case(input opcode_t o, input logic [31:0] a, input logic [31:0] b,
                               input logic [15:0] imm, input logic exp_t, input logic [31:0] exp_pc,
                               input string name);
        op = o; ra = {a, 96'h0}; rb = {b, 96'h0}; i16 = imm; pc_in = 32'h40;
        tick();
        checks++;
        if (taken !== exp_t || pc_out !== exp_pc) begin
            errors++; $display("FAIL %s: got %b/%h expected %b/%h", name, taken, pc_out, exp_t, exp_pc);
        end
        checks++;
        if (s1[142:7] !== '0) begin errors++; $display("FAIL %s_packet: got %h expected 0 value/no write", name, s1); end
        op = NOP;
    endtask

    task automatic test_branch();
        logic en;
`ifdef ODD_PIPE_BRANCH_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        branch_case(NOP, '0, '0, '0, 1'b0, 32'h44, "nop_pc");
        branch_case(BRNZ, '0, 32'd5, 16'd4, en, en ? 32'h50 : 32'h44, "brnz_taken");
        branch_case(BRNZ, '0, 32'd0, 16'd4, 1'b0, 32'h44, "brnz_not");
        branch_case(BI, 32'h1237, '0, '0, en, en ? 32'h1234 : 32'h44, "bi");
        branch_case(BRZ, '0, 32'd0, 16'hFFFF, en, en ? 32'h3C : 32'h44, "brz_back");
    endtask

    task automatic test_back_to_back();
        ra = 128'h1; rb = '0;
        op = SHLQBII; i7 = 7'd1; rt = 7'd1; tick();
        op = SHLQBII; i7 = 7'd2; rt = 7'd2; tick();
        op = SHLQBII; i7 = 7'd3; rt = 7'd3; tick();
        op = opcode_t'(5'd31); ra = '1; tick();
        op = NOP;
        checks++;
        if (s4[142:15] !== 128'h2 || s3[142:15] !== 128'h4 || s2[142:15] !== 128'h8) begin
            errors++; $display("FAIL b2b_stages: got %h %h %h expected 2 4 8", s4[142:15], s3[142:15], s2[142:15]);
        end
        checks++;
        if (s1 !== '0) begin errors++; $display("FAIL undefined_op: got %h expected 0", s1); end
        tick(); tick(); tick();
        checks++;
        if (oo[142:8] !== {128'h2, 7'd1}) begin errors++; $display("FAIL out_op: got %h expected value 2 rt 1", oo[142:8]); end
    endtask

    task automatic test_reset_mid();
        op = SHLQBI; ra = 128'h1; rb = {32'h1, 96'h0}; pc_in = 32'h100;
        tick();
        op = NOP;
        tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (stages_or !== '0 || pc_out !== 32'h0 || taken !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got stages %h pc %h expected all 0", stages_or, pc_out);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_shift_bits();
        test_rotate();
        test_shift_bytes();
        test_gather();
        test_load_store();
        test_branch();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
